// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared constants and helpers for the channel multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the chan_mux_rr mode input
//   clog2(v)             : ceiling log2 used for elaboration-time widths
//   idx_width(n)         : channel-index width, never narrower than 1 bit
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority search.
//   req   in  N   request vector
//   start in  SW  first index examined (must be < N)
//   found out 1   at least one request bit set
//   idx   out SW  first set index found walking start, start+1, ... mod N
module rr_pick
  import chan_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [SW:0]   cand_sum;
  logic [SW-1:0] cand_idx;

  // Walk from the farthest offset down to offset 0 so the nearest
  // requester overwrites any farther one.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_sum = {1'b0, start} + (SW + 1)'(k);
      if (cand_sum >= (SW + 1)'(N)) cand_sum = cand_sum - (SW + 1)'(N);
      cand_idx = cand_sum[SW-1:0];
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel to one multiplexer with a one-entry output register.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : N packed words, channel i at [i*W +: W]
//   in_valid   : per-channel word present
//   in_ready   : per-channel accept strobe (one-hot or zero)
//   mode, sel  : 0 = fixed channel sel, 1 = round-robin
//   out_data   : registered selected word
//   out_valid  : output register FULL
//   out_ready  : downstream accept
//   out_chan   : channel that supplied out_data
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1,
  localparam int SW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan
);

  logic [W-1:0]  words [N];
  logic [N-1:0]  fixed_req;
  logic [N-1:0]  pick_req;
  logic [SW-1:0] pick_start;
  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          load_en;

  logic [W-1:0]  out_data_reg,  out_data_next;
  logic [SW-1:0] out_chan_reg,  out_chan_next;
  logic          out_valid_reg, out_valid_next;
  logic [SW-1:0] ptr_reg,       ptr_next;

  // The register can take a word when empty or when its word leaves now.
  assign load_en = (!out_valid_reg || out_ready) && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign words[gi]     = in_data[gi*W +: W];
      // A sel value >= N matches no bit, so it yields no grant.
      assign fixed_req[gi] = in_valid[gi] && (sel == SW'(gi));
      assign in_ready[gi]  = load_en && pick_found && (pick_idx == SW'(gi));
    end
  endgenerate

  // Fixed mode reuses the same search with a single-bit mask; the start
  // point is irrelevant there since at most one request is set.
  assign pick_req   = (mode == MODE_RR) ? in_valid : fixed_req;
  assign pick_start = (ptr_reg == SW'(N - 1)) ? '0 : ptr_reg + SW'(1);

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    out_data_next  = out_data_reg;
    out_chan_next  = out_chan_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    if (load_en) begin
      if (pick_found) begin
        out_data_next  = words[pick_idx];
        out_chan_next  = pick_idx;
        out_valid_next = 1'b1;
        if (mode == MODE_RR) ptr_next = pick_idx;
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= SW'(N - 1);
    end else begin
      out_data_reg  <= out_data_next;
      out_chan_reg  <= out_chan_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: doc/chan_mux_rr.md
CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter W, default 1: data width per channel; legal range 1..64.
REQ-003 Localparam SW = max(1, clog2(N)): channel-index width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_data  in  N*W  channel i data occupies bits [i*W +: W].
REQ-007 in_valid  in  N  bit i: channel i holds a word.
REQ-008 in_ready  out  N  bit i: channel i's word is accepted this cycle.
REQ-009 mode  in  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  in  SW  channel index used in fixed mode.
REQ-011 out_data  out  W  registered selected word.
REQ-012 out_valid  out  1  out_data/out_chan hold a word.
REQ-013 out_ready  in  1  downstream accepts the word this cycle.
REQ-014 out_chan  out  SW  index of the channel that supplied out_data.

Function
REQ-015 The output stage SHALL be a one-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL equal (!out_valid || out_ready) && !rst.
REQ-017 Fixed mode: the grant SHALL go to channel sel when in_valid[sel]=1 and sel<N; otherwise there is no grant.
REQ-018 Round-robin mode: the grant SHALL go to the first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo N and ending with ptr itself.
REQ-019 in_ready SHALL be one-hot or zero, and in_ready[g] SHALL equal load_en && grant[g]; the logic is combinational, with no dependency of any in_ready bit on any in_valid bit other than through the grant.
REQ-020 On a transfer (load_en && grant present): out_data <= channel g data, out_chan <= g, out_valid <= 1, all on the next edge; latency is exactly 1 cycle.
REQ-021 When load_en=1 and there is no grant, out_valid SHALL go to 0 on the next edge; out_data and out_chan hold their values.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL remain stable and all in_ready bits SHALL be 0.
REQ-023 Full throughput: with out_ready held at 1 and inputs continuously valid, one word SHALL transfer every cycle.
REQ-024 ptr SHALL update to g only on a round-robin-mode transfer; it SHALL be unchanged in fixed mode.
REQ-025 A mode or sel change SHALL take effect in the same cycle's grant evaluation; no pipeline flush is performed and a held FULL word is preserved.
REQ-026 Round-robin wrap: with ptr=N-1 the search SHALL start at channel 0.

Reset
REQ-027 While rst=1: out_valid=0, out_data=0, out_chan=0, in_ready=0, and ptr=N-1, so the first round-robin search starts at channel 0.
REQ-028 When rst is asserted mid-operation, any held word SHALL be discarded at that edge, and no input SHALL be accepted in that cycle.

Structure
REQ-029 Package chan_mux_pkg SHALL hold the mode encoding constants MODE_FIXED=0 and MODE_RR=1, and the clog2 helper used for SW.
REQ-030 The rotating priority search SHALL be a sub-module rr_pick (inputs: req[N] and start index; outputs: found and the granted index). It SHALL be purely combinational and also be used for fixed mode with a single-bit mask.

Verification (N=4, W=8)
REQ-031 Reset: assert rst for 2 cycles with all inputs valid -> out_valid=0, in_ready=0000, out_data=00; after release, mode=1 -> first word comes from channel 0.
REQ-032 Fixed mode: mode=0, sel=2, in_data={44,33,22,11}, all valid, out_ready=1 -> out_data=33 and out_chan=2 one cycle later; only in_ready[2] asserts.
REQ-033 Round-robin: all valid, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles; in_valid=1010 -> sequence 1,3,1,3.
REQ-034 Backpressure: out_ready=0 for 3 cycles while FULL with out_data=22 -> out_data stays 22, in_ready=0000; out_ready=1 -> the next word loads on the following edge.
REQ-035 Boundary: sel=2 with in_valid[2]=0 -> out_valid drops to 0; switch mode 1->0->1 -> ptr is retained; rst asserted while FULL -> out_valid=0 on the next edge.
